// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-word handshake between uart_rx and its consumer
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   modport master (output data, valid, frame_err, parity_err, overrun, input ready);
   modport slave  (input data, valid, frame_err, parity_err, overrun, output ready);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled UART receiver with valid/ready word output
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      tick,
   input  logic      rx,
   uart_rx_if.master out
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t               state_q, state_d;
   logic                 rx_meta, rx_s;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 deliver;
`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d;
   logic                 perr_q, perr_d;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         // Falling edge wins over a coincident tick: that tick is not counted.
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (tick) begin
               if (cnt_q == CNT_HALF) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = rx_s ? IDLE : DATA;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (cnt_q == CNT_LAST) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  cnt_d   = '0;
                  idx_d   = idx_q + IW'(1);
                  if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (cnt_q == CNT_LAST) begin
                  par_d   = (^shift_q) ^ rx_s;
                  cnt_d   = '0;
                  state_d = STOP;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
`endif
         // Leave at mid-stop so a back-to-back start edge is not missed.
         STOP: begin
            if (tick) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  deliver = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      data_d  = data_q;
      ferr_d  = ferr_q;
      valid_d = valid_q && !out.ready;
      ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = perr_q;
`endif
      if (deliver) begin
         if (!valid_q || out.ready) begin
            data_d  = shift_q;
            ferr_d  = !rx_s;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_q;
`endif
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign out.data      = data_q;
   assign out.valid     = valid_q;
   assign out.frame_err = ferr_q;
   assign out.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign out.parity_err = perr_q;
`else
   assign out.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx (8 data bits, x16 oversample)
module tb_uart_rx;
   logic clk = 1'b0;
   logic rst_n;
   logic tick;
   logic rx;

   uart_rx_if #(.DATA_BITS(8)) bus ();

   uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .rx    (rx),
      .out   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       ferr;
      logic       perr;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   fails = 0;
   int   ovr_seen = 0;
   logic valid_prev = 1'b0;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic fe, input logic pe);
      exp_t e;
      e.data = d;
      e.ferr = fe;
      e.perr = pe;
      exp_q.push_back(e);
   endtask

   // One bit = 16 ticks = 64 clocks. A 0 stop bit ends early so the re-armed start detector sees a clean false start.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par);
      rx = 1'b0;
      step(64);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         step(64);
      end
`ifdef UART_RX_PARITY_EN
      rx = par;
      step(64);
`else
      if (par === 1'bx) step(0);
`endif
      rx = stop_bit;
      if (stop_bit) step(64);
      else step(48);
      rx = 1'b1;
   endtask

   initial begin
      tick = 1'b0;
      forever begin
         step(3);
         tick = 1'b1;
         step(1);
         tick = 1'b0;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (bus.valid && bus.ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_word: actual data 0x%0h, required no word", bus.data);
            end else begin
               mon_e = exp_q.pop_front();
               check("word_data", int'(bus.data), int'(mon_e.data));
               check("word_frame_err", int'(bus.frame_err), int'(mon_e.ferr));
               check("word_parity_err", int'(bus.parity_err), int'(mon_e.perr));
            end
         end
         if (bus.overrun) begin
            ovr_seen++;
            check("overrun_with_held_word", int'(valid_prev), 1);
         end
         valid_prev = bus.valid;
      end
   end

   initial begin
      rst_n = 1'b0;
      rx = 1'b1;
      bus.ready = 1'b1;
      step(3);
      check("reset_valid", int'(bus.valid), 0);
      check("reset_data", int'(bus.data), 0);
      check("reset_frame_err", int'(bus.frame_err), 0);
      check("reset_parity_err", int'(bus.parity_err), 0);
      check("reset_overrun", int'(bus.overrun), 0);
      rst_n = 1'b1;
      step(20);

      push(8'hA5, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b1, ^8'hA5);
      step(64);
      check("a5_consumed", exp_q.size(), 0);
      check("a5_valid_dropped", int'(bus.valid), 0);

      rx = 1'b0;
      step(16);
      rx = 1'b1;
      step(96);
      check("false_start_no_valid", int'(bus.valid), 0);
      push(8'h5A, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b1, ^8'h5A);
      step(64);
      check("5a_consumed", exp_q.size(), 0);

      push(8'h3C, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b0, ^8'h3C);
      step(96);
      check("3c_consumed", exp_q.size(), 0);

      bus.ready = 1'b0;
      push(8'h11, 1'b0, 1'b0);
      send_frame(8'h11, 1'b1, ^8'h11);
      send_frame(8'h22, 1'b1, ^8'h22);
      step(64);
      check("overrun_count", ovr_seen, 1);
      check("held_valid", int'(bus.valid), 1);
      check("held_data", int'(bus.data), 8'h11);
      bus.ready = 1'b1;
      step(2);
      check("held_word_accepted", exp_q.size(), 0);
      push(8'h33, 1'b0, 1'b0);
      send_frame(8'h33, 1'b1, ^8'h33);
      step(64);
      check("33_consumed", exp_q.size(), 0);

      bus.ready = 1'b0;
      push(8'h44, 1'b0, 1'b0);
      send_frame(8'h44, 1'b1, ^8'h44);
      step(32);
      check("pre_reset_held_data", int'(bus.data), 8'h44);
      rx = 1'b0;
      step(64);
      rx = 1'b1;
      step(192);
      rst_n = 1'b0;
      exp_q.delete();
      step(2);
      check("midframe_reset_valid", int'(bus.valid), 0);
      check("midframe_reset_data", int'(bus.data), 0);
      check("midframe_reset_frame_err", int'(bus.frame_err), 0);
      check("midframe_reset_parity_err", int'(bus.parity_err), 0);
      check("midframe_reset_overrun", int'(bus.overrun), 0);
      rst_n = 1'b1;
      step(400);
      check("post_reset_idle_valid", int'(bus.valid), 0);
      bus.ready = 1'b1;
      push(8'h42, 1'b0, 1'b0);
      send_frame(8'h42, 1'b1, ^8'h42);
      step(64);
      check("42_consumed", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
      push(8'h07, 1'b0, 1'b1);
      send_frame(8'h07, 1'b1, 1'b0);
      step(64);
      push(8'h07, 1'b0, 1'b0);
      send_frame(8'h07, 1'b1, 1'b1);
      step(64);
      check("parity_words_consumed", exp_q.size(), 0);
`endif

      check("total_overruns", ovr_seen, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
